pp_group_accum: RTL and testbench

//  - Stage directly downstream of the partial-product align stage in the MAC subsystem.
//  - Consumes one aligned 15-bit two's-complement partial product per valid beat.
//  - Sums GROUP beats into one wide signed result, which feeds the normaliser.
//  - Carries the group's max_exp and Q_frac alongside the sum.

---
 rtl/mac_pkg.sv | 14 +
 rtl/pp_acc_add.sv | 36 +++
 rtl/pp_group_accum.sv | 150 +++++++++++++++
 tb/tb_pp_group_accum.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Constants and types shared by the MAC subsystem stages (align, group accumulate, normalise).
package mac_pkg;

    localparam int PP_W  = 15;
    localparam int EXP_W = 6;
    localparam int QF_W  = 5;
    localparam int CNT_W = 4;

    typedef enum logic {
        ST_IDLE,
        ST_ACC
    } acc_state_e;

endpackage

// File: rtl/pp_acc_add.sv
// Signed accumulator adder: ACC_W accumulator plus sign-extended PP_W partial product.
// With PP_GROUP_ACCUM_SAT_EN defined the result clamps and ovf_o flags the clamp.
module pp_acc_add
    import mac_pkg::*;
#(
    parameter int ACC_W = 19
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [PP_W-1:0]  pp_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             ovf_o
);

    logic [ACC_W-1:0] pp_ext;

    assign pp_ext = ACC_W'($signed(pp_i));

`ifdef PP_GROUP_ACCUM_SAT_EN
    logic [ACC_W:0] wide;

    // One guard bit: the top two bits disagree exactly when the true sum leaves the ACC_W range.
    assign wide  = {acc_i[ACC_W-1], acc_i} + {pp_ext[ACC_W-1], pp_ext};
    assign ovf_o = wide[ACC_W] ^ wide[ACC_W-1];

    always_comb begin
        sum_o = wide[ACC_W-1:0];
        if (ovf_o) begin
            sum_o = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign sum_o = acc_i + pp_ext;
    assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/pp_group_accum.sv
// Sums GROUP aligned partial products into one signed result with the group's max_exp / Q_frac.
// Optional saturating arithmetic is enabled by defining PP_GROUP_ACCUM_SAT_EN.
module pp_group_accum
    import mac_pkg::*;
#(
    parameter int GROUP = 9,
    parameter int ACC_W = 19
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [PP_W-1:0]  align_pp,
    input  logic [EXP_W-1:0] i_max_exp,
    input  logic [QF_W-1:0]  i_Q_frac,
    input  logic             i_flush,
    output logic             o_valid,
    output logic [ACC_W-1:0] o_sum,
    output logic [EXP_W-1:0] o_max_exp,
    output logic [QF_W-1:0]  o_Q_frac,
    output logic             o_err,
    output logic [CNT_W-1:0] o_cnt
);

    acc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [QF_W-1:0]  qf_q, qf_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [EXP_W-1:0] oexp_q, oexp_d;
    logic [QF_W-1:0]  oqf_q, oqf_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic             base_zero;
    logic             beat_last;
    logic             mismatch;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = (i_valid && GROUP > 1) ? ST_ACC : ST_IDLE;
        end else if (i_valid) begin
            state_d = beat_last ? ST_IDLE : ST_ACC;
        end
    end

    // A flushed or idle cycle starts from an empty group, so the adder sees zero.
    always_comb begin
        base_zero = i_flush || (state_q == ST_IDLE);
        beat_last = 1'b0;
        mismatch  = 1'b0;
        if (i_valid && !i_flush) begin
            beat_last = base_zero ? (GROUP == 1) : (cnt_q == CNT_W'(GROUP - 1));
        end
        if (i_valid && !base_zero) begin
            mismatch = (i_max_exp != exp_q) || (i_Q_frac != qf_q);
        end
    end

    assign acc_base = base_zero ? '0 : acc_q;

    pp_acc_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc_i (acc_base),
        .pp_i  (align_pp),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        exp_d   = exp_q;
        qf_d    = qf_q;
        sum_d   = sum_q;
        oexp_d  = oexp_q;
        oqf_d   = oqf_q;
        valid_d = beat_last;
        err_d   = err_q | mismatch | (i_valid & add_ovf);

        if (i_flush) begin
            cnt_d = (i_valid && GROUP > 1) ? CNT_W'(1) : '0;
        end else if (i_valid) begin
            cnt_d = beat_last ? '0 : cnt_q + CNT_W'(1);
        end

        if (i_valid || i_flush) begin
            acc_d = (state_d == ST_ACC) ? add_sum : '0;
        end

        if (i_valid && base_zero) begin
            exp_d = i_max_exp;
            qf_d  = i_Q_frac;
        end

        // A single-beat group has no latched metadata yet, so it comes straight from the inputs.
        if (beat_last) begin
            sum_d  = add_sum;
            oexp_d = base_zero ? i_max_exp : exp_q;
            oqf_d  = base_zero ? i_Q_frac  : qf_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            exp_q   <= '0;
            qf_q    <= '0;
            sum_q   <= '0;
            oexp_q  <= '0;
            oqf_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            exp_q   <= exp_d;
            qf_q    <= qf_d;
            sum_q   <= sum_d;
            oexp_q  <= oexp_d;
            oqf_q   <= oqf_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_sum     = sum_q;
    assign o_max_exp = oexp_q;
    assign o_Q_frac  = oqf_q;
    assign o_err     = err_q;
    assign o_cnt     = cnt_q;

endmodule

// File: tb/tb_pp_group_accum.sv
// Self-checking bench for pp_group_accum against a queue-based group-sum reference model.
module tb_pp_group_accum;
    import mac_pkg::*;

    localparam int GROUP = 9;
    localparam int ACC_W = 19;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid;
    logic [PP_W-1:0]  pp;
    logic [EXP_W-1:0] mexp;
    logic [QF_W-1:0]  qf;
    logic             flush;
    logic             o_valid;
    logic [ACC_W-1:0] o_sum;
    logic [EXP_W-1:0] o_max_exp;
    logic [QF_W-1:0]  o_Q_frac;
    logic             o_err;
    logic [CNT_W-1:0] o_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the beats of the open group, plus the expected output registers.
    int               grp[$];
    logic [EXP_W-1:0] m_exp;
    logic [QF_W-1:0]  m_qf;
    logic             m_err;
    logic             m_valid;
    logic [ACC_W-1:0] m_sum;
    logic [EXP_W-1:0] m_oexp;
    logic [QF_W-1:0]  m_oqf;

    pp_group_accum #(
        .GROUP (GROUP),
        .ACC_W (ACC_W)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (valid),
        .align_pp  (pp),
        .i_max_exp (mexp),
        .i_Q_frac  (qf),
        .i_flush   (flush),
        .o_valid   (o_valid),
        .o_sum     (o_sum),
        .o_max_exp (o_max_exp),
        .o_Q_frac  (o_Q_frac),
        .o_err     (o_err),
        .o_cnt     (o_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [CNT_W-1:0] cnt_exp;
        cnt_exp = CNT_W'(grp.size());
        check({tag, ".valid"}, 32'(o_valid), 32'(m_valid));
        check({tag, ".cnt"},   32'(o_cnt),   32'(cnt_exp));
        check({tag, ".err"},   32'(o_err),   32'(m_err));
        check({tag, ".sum"},   32'(o_sum),   32'(m_sum));
        check({tag, ".exp"},   32'(o_max_exp), 32'(m_oexp));
        check({tag, ".qf"},    32'(o_Q_frac),  32'(m_oqf));
    endtask

    task automatic model_reset();
        grp.delete();
        m_exp   = '0;
        m_qf    = '0;
        m_err   = 1'b0;
        m_valid = 1'b0;
        m_sum   = '0;
        m_oexp  = '0;
        m_oqf   = '0;
    endtask

    task automatic model_beat(input logic v, input logic [PP_W-1:0] p,
                              input logic [EXP_W-1:0] e, input logic [QF_W-1:0] q,
                              input logic f);
        m_valid = 1'b0;
        if (f) grp.delete();
        if (v) begin
            if (grp.size() == 0) begin
                m_exp = e;
                m_qf  = q;
            end else if (e != m_exp || q != m_qf) begin
                m_err = 1'b1;
            end
            grp.push_back(int'($signed(p)));
            if (grp.size() == GROUP && !f) begin
                int s = 0;
                foreach (grp[i]) s += grp[i];
                m_sum   = ACC_W'(s);
                m_oexp  = m_exp;
                m_oqf   = m_qf;
                m_valid = 1'b1;
                grp.delete();
            end
        end
    endtask

    task automatic step(input logic v, input logic [PP_W-1:0] p, input logic [EXP_W-1:0] e,
                        input logic [QF_W-1:0] q, input logic f, input string tag);
        @(negedge clk);
        valid = v;
        pp    = p;
        mexp  = e;
        qf    = q;
        flush = f;
        model_beat(v, p, e, q, f);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [PP_W-1:0]  rpp;
        logic [EXP_W-1:0] rexp;
        logic [QF_W-1:0]  rqf;

        rst_n = 1'b0;
        valid = 1'b0;
        pp    = '0;
        mexp  = '0;
        qf    = '0;
        flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full group of identical beats.
        for (int i = 0; i < GROUP; i++) step(1'b1, 15'h0010, 6'd20, 5'd3, 1'b0, "full");
        check("full.const_sum", 32'(o_sum), 32'h00090);
        check("full.const_exp", 32'(o_max_exp), 32'd20);
        step(1'b0, 15'h0000, 6'd20, 5'd3, 1'b0, "full.hold");

        // Signed mix: largest positive and most negative partial products.
        for (int i = 0; i < 4; i++) step(1'b1, 15'h3FFF, 6'd7, 5'd1, 1'b0, "mix");
        for (int i = 0; i < 5; i++) step(1'b1, 15'h4000, 6'd7, 5'd1, 1'b0, "mix");
        check("mix.const_sum", 32'(o_sum), 32'h7BFFC);

        // Random bubbles, then a second group starting the very next cycle.
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < GROUP; i++) begin
                if (g == 0) begin
                    repeat ($urandom_range(0, 2)) begin
                        rpp = 15'($urandom);
                        step(1'b0, rpp, 6'd33, 5'd9, 1'b0, "bubble.idle");
                    end
                end
                rpp = 15'($urandom);
                step(1'b1, rpp, 6'd33, 5'd9, 1'b0, "bubble.beat");
            end
        end

        // Randomised groups with per-group metadata and random gaps.
        for (int g = 0; g < 4; g++) begin
            rexp = 6'($urandom);
            rqf  = 5'($urandom);
            for (int i = 0; i < GROUP; i++) begin
                if ($urandom_range(0, 3) == 0) step(1'b0, 15'h1234, rexp, rqf, 1'b0, "rand.idle");
                rpp = 15'($urandom);
                step(1'b1, rpp, rexp, rqf, 1'b0, "rand.beat");
            end
        end

        // Flush together with a valid beat restarts the group with that beat.
        for (int i = 0; i < 5; i++) step(1'b1, 15'h0001, 6'd12, 5'd4, 1'b0, "flush.pre");
        step(1'b1, 15'h0001, 6'd12, 5'd4, 1'b1, "flush.hit");
        check("flush.const_cnt", 32'(o_cnt), 32'd1);
        for (int i = 0; i < GROUP - 1; i++) step(1'b1, 15'h0001, 6'd12, 5'd4, 1'b0, "flush.post");
        check("flush.const_sum", 32'(o_sum), 32'd9);

        // Flush landing on the completion beat suppresses the pulse.
        for (int i = 0; i < GROUP - 1; i++) step(1'b1, 15'h0002, 6'd12, 5'd4, 1'b0, "flush_last.pre");
        step(1'b1, 15'h0005, 6'd12, 5'd4, 1'b1, "flush_last.hit");
        step(1'b1, 15'h0000, 6'd12, 5'd4, 1'b1, "flush_last.clear");
        step(1'b0, 15'h0000, 6'd12, 5'd4, 1'b1, "flush_last.empty");

        // Asynchronous reset between clock edges in the middle of a group.
        for (int i = 0; i < 4; i++) step(1'b1, 15'h0100, 6'd5, 5'd2, 1'b0, "rst.pre");
        @(negedge clk);
        valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst.async");
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < GROUP; i++) begin
            rpp = 15'($urandom);
            step(1'b1, rpp, 6'd5, 5'd2, 1'b0, "rst.post");
        end

        // Metadata change on beat 3 raises a sticky error; the beat is still summed.
        for (int i = 0; i < GROUP; i++) begin
            step(1'b1, 15'h0003, (i == 2) ? 6'd21 : 6'd20, 5'd3, 1'b0, "err.grp");
        end
        for (int i = 0; i < GROUP; i++) step(1'b1, 15'h0002, 6'd40, 5'd6, 1'b0, "err.sticky");
        check("err.const_sticky", 32'(o_err), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
